// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and constants for the program loader / run controller.
package prog_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STRT   = 3'd2,
        ST_RUN    = 3'd3,
        ST_FINISH = 3'd4
    } prog_run_state_t;

    localparam logic MEM_SEL_IMEM = 1'b0;
    localparam logic MEM_SEL_DMEM = 1'b1;

    localparam int INSN_W  = 9;
    localparam int BYTE_W  = 8;
    localparam int CYCLE_W = 16;

endpackage

// File: rtl/prog_run_ctrl_load_ptr.sv
// Saturating write pointer: the all-ones slot is still written, later advances are refused.
module load_ptr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         adv,
    output logic [W-1:0] ptr,
    output logic         wr_ok,
    output logic         ovf
);

    logic sat;

    assign wr_ok = adv & ~sat;
    assign ovf   = adv & sat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            sat <= 1'b0;
        end else if (clr) begin
            ptr <= '0;
            sat <= 1'b0;
        end else if (wr_ok) begin
            if (&ptr) begin
                sat <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_run_ctrl.sv
// Loads imem/dmem over a valid/ready port, then pulses START and times the datapath run.
module prog_run_ctrl
    import prog_run_ctrl_pkg::*;
#(
    parameter int          IA_W         = 10,
    parameter int          DA_W         = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSN_W-1:0]   in_data,
    input  logic                in_sel,
    input  logic                in_last,
    input  logic                go,
    output logic                imem_we,
    output logic [IA_W-1:0]     imem_addr,
    output logic [INSN_W-1:0]   imem_wdata,
    output logic                dmem_we,
    output logic [DA_W-1:0]     dmem_addr,
    output logic [BYTE_W-1:0]   dmem_wdata,
    output logic                START,
    input  logic                DONE,
    output logic                busy,
    output logic                run_done,
    output logic                timeout,
    output logic [CYCLE_W-1:0]  cycles,
    output logic                load_err,
    output logic [2:0]          state
);

    localparam int SC_W = $clog2(START_CYCLES + 1);
    localparam logic [SC_W-1:0] STRT_LAST = SC_W'(START_CYCLES - 1);

    prog_run_state_t   state_q;
    logic [SC_W-1:0]   strt_cnt;
    logic [IA_W-1:0]   iptr;
    logic [DA_W-1:0]   dptr;
    logic              accept;
    logic              i_adv;
    logic              d_adv;
    logic              ptr_clr;
    logic              i_wr_ok;
    logic              d_wr_ok;
    logic              i_ovf;
    logic              d_ovf;
    logic [CYCLE_W-1:0] cyc_next;

    // Handshake: a beat transfers on a rising CLK edge where in_valid && in_ready;
    // in_ready depends only on state, so it never combinationally follows in_valid.
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_FINISH);
    assign busy     = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign state    = state_q;

    assign accept   = in_valid & in_ready;
    assign i_adv    = accept & (in_sel == MEM_SEL_IMEM);
    assign d_adv    = accept & (in_sel == MEM_SEL_DMEM);
    assign ptr_clr  = accept & in_last;
    assign cyc_next = (&cycles) ? cycles : cycles + 16'd1;

    load_ptr #(.W(IA_W)) u_iptr (
        .clk   (CLK),
        .rst_n (reset_n),
        .clr   (ptr_clr),
        .adv   (i_adv),
        .ptr   (iptr),
        .wr_ok (i_wr_ok),
        .ovf   (i_ovf)
    );

    load_ptr #(.W(DA_W)) u_dptr (
        .clk   (CLK),
        .rst_n (reset_n),
        .clr   (ptr_clr),
        .adv   (d_adv),
        .ptr   (dptr),
        .wr_ok (d_wr_ok),
        .ovf   (d_ovf)
    );

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= i_wr_ok;
            dmem_we <= d_wr_ok;
            if (i_wr_ok) begin
                imem_addr  <= iptr;
                imem_wdata <= in_data;
            end
            if (d_wr_ok) begin
                dmem_addr  <= dptr;
                dmem_wdata <= in_data[BYTE_W-1:0];
            end
            if (i_ovf || d_ovf) begin
                load_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            START    <= 1'b0;
            strt_cnt <= '0;
            run_done <= 1'b0;
            timeout  <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISH: begin
                    // A beat takes priority over go in the same cycle.
                    if (accept) begin
                        state_q  <= in_last ? ST_IDLE : ST_LOAD;
                        run_done <= 1'b0;
                        timeout  <= 1'b0;
                        cycles   <= '0;
                    end else if (go) begin
                        state_q  <= ST_STRT;
                        START    <= 1'b1;
                        strt_cnt <= '0;
                        run_done <= 1'b0;
                        timeout  <= 1'b0;
                        cycles   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept && in_last) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_STRT: begin
                    // DONE is stale until the datapath is reinitialised, so it is not looked at here.
                    if (strt_cnt == STRT_LAST) begin
                        state_q <= ST_RUN;
                        START   <= 1'b0;
                    end else begin
                        strt_cnt <= strt_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    cycles <= cyc_next;
                    if (DONE) begin
                        state_q  <= ST_FINISH;
                        run_done <= 1'b1;
                    end else if (cyc_next >= TIMEOUT) begin
                        state_q  <= ST_FINISH;
                        run_done <= 1'b1;
                        timeout  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    START   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Randomised scoreboard bench for prog_run_ctrl with a count-based memory/run model.
module tb_prog_run_ctrl;
    import prog_run_ctrl_pkg::*;

    localparam int          IA_W         = 2;
    localparam int          DA_W         = 8;
    localparam int          START_CYCLES = 2;
    localparam logic [15:0] TIMEOUT      = 16'd20;
    localparam int          ISLOTS       = 1 << IA_W;
    localparam int          DSLOTS       = 1 << DA_W;

    logic              CLK;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [8:0]        in_data;
    logic              in_sel;
    logic              in_last;
    logic              go;
    logic              imem_we;
    logic [IA_W-1:0]   imem_addr;
    logic [8:0]        imem_wdata;
    logic              dmem_we;
    logic [DA_W-1:0]   dmem_addr;
    logic [7:0]        dmem_wdata;
    logic              START;
    logic              DONE;
    logic              busy;
    logic              run_done;
    logic              timeout;
    logic [15:0]       cycles;
    logic              load_err;
    logic [2:0]        state;

    prog_run_ctrl #(
        .IA_W         (IA_W),
        .DA_W         (DA_W),
        .START_CYCLES (START_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .CLK        (CLK),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .go         (go),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .START      (START),
        .DONE       (DONE),
        .busy       (busy),
        .run_done   (run_done),
        .timeout    (timeout),
        .cycles     (cycles),
        .load_err   (load_err),
        .state      (state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          checks;
    int          failures;
    logic [31:0] imem_q[$];
    logic [31:0] dmem_q[$];
    logic [31:0] run_q[$];
    int          icount;
    int          dcount;
    bit          load_err_exp;
    bit          run_done_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge CLK) begin
        if (reset_n) begin
            if (imem_we) begin
                if (imem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL imem_unexpected: actual=%0h expected=none", {imem_addr, imem_wdata});
                end else begin
                    check("imem_write", {imem_addr, imem_wdata}, imem_q.pop_front());
                end
            end
            if (dmem_we) begin
                if (dmem_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL dmem_unexpected: actual=%0h expected=none", {dmem_addr, dmem_wdata});
                end else begin
                    check("dmem_write", {dmem_addr, dmem_wdata}, dmem_q.pop_front());
                end
            end
            if (run_done && !run_done_prev) begin
                if (run_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL run_unexpected: actual=%0h expected=none", {timeout, cycles});
                end else begin
                    check("run_result", {timeout, cycles}, run_q.pop_front());
                end
            end
            run_done_prev = run_done;
        end else begin
            run_done_prev = 1'b0;
        end
    end

    // driver tasks (all start and end one time unit after a rising edge)
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic send_beat(input bit sel, input logic [8:0] data, input bit last, input bit with_go);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL beat_ready_wait: actual=0 expected=1");
            return;
        end
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        in_last  = last;
        go       = with_go;
        if (sel == MEM_SEL_IMEM) begin
            if (icount < ISLOTS) begin
                imem_q.push_back(32'((icount << 9) | int'(data)));
                icount++;
            end else begin
                load_err_exp = 1'b1;
            end
        end else begin
            if (dcount < DSLOTS) begin
                dmem_q.push_back(32'((dcount << 8) | int'(data[7:0])));
                dcount++;
            end else begin
                load_err_exp = 1'b1;
            end
        end
        if (last) begin
            icount = 0;
            dcount = 0;
        end
        @(posedge CLK); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        go       = 1'b0;
    endtask

    // d = RUN cycles with DONE low before DONE rises; stale = DONE level during STRT
    task automatic do_run(input int d, input bit stale);
        int high  = 0;
        int guard = 0;
        int exp_c = d + 1;
        bit exp_t = 1'b0;
        if (exp_c > int'(TIMEOUT)) begin
            exp_c = int'(TIMEOUT);
            exp_t = 1'b1;
        end
        run_q.push_back(32'((int'(exp_t) << 16) | exp_c));
        go   = 1'b1;
        DONE = stale;
        @(posedge CLK); #1;
        go = 1'b0;
        while (START && guard < 20) begin
            high++;
            @(posedge CLK); #1;
            guard++;
        end
        check("start_high_cycles", high, START_CYCLES);
        DONE = 1'b0;
        guard = 0;
        for (int k = 0; k < 60 && !run_done; k++) begin
            if (k == d) DONE = 1'b1;
            @(posedge CLK); #1;
            guard++;
        end
        if (!run_done) begin
            checks++; failures++;
            $display("FAIL run_done_wait: actual=0 expected=1");
        end
        DONE = 1'b0;
        check("finish_state", state, ST_FINISH);
        check("finish_busy", busy, 1'b0);
    endtask

    task automatic rand_load();
        int n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) begin
            bit         sel = 1'($urandom_range(0, 1));
            logic [8:0] dat = 9'($urandom_range(0, 511));
            send_beat(sel, dat, i == n - 1, 1'b0);
            if (i != n - 1) idle($urandom_range(0, 2));
        end
        check("load_end_state", state, ST_IDLE);
        check("load_err", load_err, load_err_exp);
    endtask

    initial begin
        checks = 0; failures = 0;
        icount = 0; dcount = 0; load_err_exp = 1'b0; run_done_prev = 1'b0;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        in_last = 1'b0; go = 1'b0; DONE = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_start", START, 1'b0);
        check("rst_we", {imem_we, dmem_we}, 2'b00);
        check("rst_flags", {busy, run_done, timeout, load_err}, 4'b0000);
        check("rst_cycles", cycles, 16'd0);
        @(negedge CLK) reset_n = 1'b1;
        @(posedge CLK); #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_state", state, ST_IDLE);

        // directed three-beat program load
        send_beat(MEM_SEL_IMEM, 9'h1A0, 1'b0, 1'b0);
        check("load_state", state, ST_LOAD);
        check("load_busy", busy, 1'b1);
        send_beat(MEM_SEL_IMEM, 9'h0F3, 1'b0, 1'b0);
        send_beat(MEM_SEL_IMEM, 9'h155, 1'b1, 1'b0);
        check("load3_end_state", state, ST_IDLE);

        // interleaved data/instruction beats
        send_beat(MEM_SEL_DMEM, 9'h07F, 1'b0, 1'b0);
        send_beat(MEM_SEL_IMEM, 9'h0AA, 1'b0, 1'b0);
        send_beat(MEM_SEL_DMEM, 9'h101, 1'b1, 1'b0);
        idle(2);

        // runs: DONE after 5, DONE exactly at limit, stale DONE then timeout
        do_run(5, 1'b0);
        do_run(19, 1'b0);
        do_run(40, 1'b1);
        check("timeout_flag", timeout, 1'b1);
        do_run(0, 1'b1);

        // beat and go together in FINISH: the beat wins
        send_beat(MEM_SEL_DMEM, 9'h033, 1'b0, 1'b1);
        check("collide_state", state, ST_LOAD);
        check("collide_start", START, 1'b0);
        check("collide_clear", {run_done, timeout, cycles}, 18'd0);
        send_beat(MEM_SEL_IMEM, 9'h044, 1'b0, 1'b1);
        check("go_in_load_state", state, ST_LOAD);
        check("go_in_load_start", START, 1'b0);
        send_beat(MEM_SEL_DMEM, 9'h055, 1'b1, 1'b0);

        // instruction memory overflow
        for (int i = 0; i < 5; i++) begin
            send_beat(MEM_SEL_IMEM, 9'(9'h100 + i), i == 4, 1'b0);
        end
        idle(2);
        check("overflow_load_err", load_err, 1'b1);

        // randomised mix of loads and runs
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 1) == 0) begin
                rand_load();
            end else begin
                do_run($urandom_range(0, 24), 1'($urandom_range(0, 1)));
            end
            idle($urandom_range(0, 2));
        end

        // reset in the middle of a run
        go = 1'b1;
        @(posedge CLK); #1;
        go = 1'b0;
        idle(START_CYCLES + 3);
        check("pre_reset_state", state, ST_RUN);
        #2 reset_n = 1'b0;
        #1;
        check("midrun_rst_start", START, 1'b0);
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_cycles", cycles, 16'd0);
        check("midrun_rst_state", state, ST_IDLE);
        check("midrun_rst_load_err", load_err, 1'b0);
        icount = 0; dcount = 0; load_err_exp = 1'b0;
        @(negedge CLK) reset_n = 1'b1;
        @(posedge CLK); #1;

        // recovery after reset
        rand_load();
        do_run(3, 1'b0);
        idle(3);

        check("imem_q_empty", imem_q.size(), 0);
        check("dmem_q_empty", dmem_q.size(), 0);
        check("run_q_empty", run_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Upstream sequencer for the single-cycle 9-bit-instruction datapath.
- Streams a program into instruction memory and initial bytes into data memory over a valid/ready port.
- Then drives the datapath's START for a fixed number of cycles and times the run until the datapath raises DONE.
- Reports the cycle count and a timeout flag to the testbench or host.

Parameters:
IA_W, 10, instruction memory address width (words of 9 bits)
DA_W, 8, data memory address width (bytes)
START_CYCLES, 2, cycles START is held high before a run
TIMEOUT, 16'hFFFF, run-cycle limit before forced abort

Ports:
CLK  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  load beat valid
in_ready  output  1  loader can accept a beat
in_data  input  9  beat payload; dmem beats use [7:0]
in_sel  input  1  0 = instruction memory, 1 = data memory
in_last  input  1  final beat of the load
go  input  1  single-cycle request to start a run
imem_we  output  1  instruction memory write strobe
imem_addr  output  IA_W  instruction memory write address
imem_wdata  output  9  instruction word
dmem_we  output  1  data memory write strobe
dmem_addr  output  DA_W  data memory write address
dmem_wdata  output  8  data byte
START  output  1  to datapath START (PC init / flag reset)
DONE  input  1  from datapath DONE
busy  output  1  high in any state except IDLE and FINISH
run_done  output  1  run ended (DONE or timeout); held
timeout  output  1  run ended by timeout; held
cycles  output  16  run-cycle count; held after run ends
load_err  output  1  sticky; address overflow during load

Behaviour:
- Reset: asynchronous, active-low, on assertion of reset_n low.
  - State IDLE.
  - Outputs: START, imem_we, dmem_we, busy, run_done, timeout, load_err all 0; cycles 0.
  - Both write pointers cleared to 0.
  - Reset mid-run or mid-load drops START and write strobes immediately.
- States: IDLE, LOAD, STRT, RUN, FINISH.
- in_ready = 1 in IDLE, LOAD and FINISH; 0 in STRT and RUN.
- A beat is accepted on a rising edge with in_valid & in_ready.
- Write latency: a beat accepted at edge n produces a one-cycle strobe registered at edge n:
  - in_sel = 0: imem_we=1, imem_addr = ipointer, imem_wdata = in_data.
  - in_sel = 1: dmem_we=1, dmem_addr = dpointer, dmem_wdata = in_data[7:0].
  - After the write, the selected pointer increments.
- Pointer wrap: a write whose pointer equals the all-ones address still occurs.
  - The pointer then saturates rather than wrapping.
  - Any further beat to that memory is dropped (no strobe) and sets load_err.
- Transitions:
  - IDLE/FINISH + accepted beat -> LOAD. run_done, timeout and cycles clear. A beat with in_last goes directly back to IDLE after its write.
  - LOAD + accepted beat with in_last -> IDLE; both pointers clear to 0.
  - IDLE/FINISH + go (and no accepted beat that cycle) -> STRT. START=1, run_done/timeout/cycles clear, STRT counter = 0.
  - STRT: START held for exactly START_CYCLES cycles, then -> RUN with START=0. DONE is ignored in STRT because the datapath's DONE is stale until reinitialised.
  - RUN: cycles increments by 1 every cycle, saturating at 16'hFFFF.
    - DONE=1 -> FINISH, run_done=1. cycles holds the value including the DONE cycle.
    - cycles reaching TIMEOUT without DONE -> FINISH, run_done=1, timeout=1.
  - FINISH: holds results until the next beat or go.
- Ignored inputs: go is ignored in LOAD, STRT and RUN. in_valid is ignored (in_ready low) in STRT and RUN.
- Simultaneous accepted beat and go in IDLE/FINISH: the beat wins, go is dropped.
- load_err clears only on reset.

Decomposition:
- Shared package gets a typedef enum of the five states (prog_run_state_t) and constants MEM_SEL_IMEM=0 and MEM_SEL_DMEM=1.
- One natural sub-module: load_ptr, a saturating pointer with overflow flag, instantiated twice (IA_W and DA_W).
- FSM, START timer and cycle counter live in the top.

Test Plan:
- Reset held low, then released -> all outputs 0, in_ready=1, state IDLE.
- Load 3 imem beats (9'h1A0, 9'h0F3, 9'h155; last on third) -> imem_we pulses at addr 0, 1, 2 with those data; returns to IDLE.
- Interleave dmem beats 8'h7F, 8'h01 with one imem beat -> dmem_addr 0, 1; imem_addr 0; pointers independent.
- go, DONE driven high 5 cycles after START falls -> START high exactly 2 cycles; run_done=1; cycles=6; timeout=0.
- DONE held high during STRT, then low until TIMEOUT=20 -> STRT not exited early; timeout=1, run_done=1, cycles=20.
- Overflow, beat+go collision and mid-run reset:
  - IA_W=2: 5 imem beats -> 4 writes, 5th dropped, load_err=1.
  - go together with in_valid in FINISH -> LOAD entered, no START.
  - reset_n low in RUN -> START, busy and cycles to 0 immediately.
